game_session_ctrl: RTL and testbench
====================================

GAME_SESSION_CTRL -- requirements
Module: game_session_ctrl

Interface
REQ-001 Parameter RATING_WIDTH, 8, width of rating and high-score counters.
REQ-002 Parameter LEVEL_WIDTH, 4, width of level counter.
REQ-003 Parameter NUM_LIVES, 3, lives per game, legal range 1..7.
REQ-004 Parameter RESPAWN_CYCLES, 16, cycles spent in LIFE_LOST, minimum 1.
REQ-005 Parameter NUM_IMAGES, 8, overlay image count, minimum 8.
REQ-006 clk  in  1  clock; all state updates on the rising edge.
REQ-007 rst_n  in  1  reset, asynchronous, active-low.
REQ-008 i_is_win  in  1  level-won strobe from the safe-zone block.
REQ-009 i_is_lose  in  1  level-lost strobe from the safe-zone block.
REQ-010 i_ready  in  1  level generator finished.
REQ-011 i_start_game  in  1  debounced single-cycle start/resume pulse.
REQ-012 i_pause_game  in  1  debounced single-cycle pause pulse.
REQ-013 o_regenerate_level  out  1  one-cycle request to the level generator.
REQ-014 o_game_running  out  1  high only in RUNNING.
REQ-015 o_current_rating  out  RATING_WIDTH  score of the current game.
REQ-016 o_high_score  out  RATING_WIDTH  best score since reset.
REQ-017 o_new_record  out  1  one-cycle pulse when the high score is replaced.
REQ-018 o_lives  out  3  remaining lives.
REQ-019 o_level  out  LEVEL_WIDTH  current level index.
REQ-020 o_image_number  out  $clog2(NUM_IMAGES)  overlay image select.

Function
REQ-021 The FSM SHALL have the states IDLE, GENERATING, RUNNING, PAUSED, LIFE_LOST and GAME_OVER.
REQ-022 IDLE or GAME_OVER with i_start_game SHALL go to GENERATING and load rating=0, level=0, lives=NUM_LIVES.
REQ-023 GENERATING SHALL go to RUNNING on the cycle i_ready is sampled high.
REQ-024 In RUNNING, i_is_win SHALL go to GENERATING, add 1 to rating (saturating at all-ones) and add 1 to level (saturating).
REQ-025 In RUNNING, i_is_lose with lives>1 SHALL decrement lives and go to LIFE_LOST; rating and level are kept.
REQ-026 In RUNNING, i_is_lose with lives==1 SHALL set lives=0 and go to GAME_OVER.
REQ-027 If i_is_win and i_is_lose are high in the same cycle, win SHALL take priority.
REQ-028 Win and lose SHALL take priority over i_pause_game; with neither, i_pause_game in RUNNING SHALL go to PAUSED.
REQ-029 PAUSED SHALL go to RUNNING on i_start_game; win, lose and pause inputs are ignored while PAUSED.
REQ-030 LIFE_LOST SHALL load a down-counter with RESPAWN_CYCLES-1 on entry and go to GENERATING on the cycle after the counter reaches 0, so the state lasts exactly RESPAWN_CYCLES cycles.
REQ-031 Win, lose and ready inputs SHALL be ignored outside the states that consume them.
REQ-032 o_regenerate_level SHALL be asserted for exactly one cycle, in the cycle where the current state is not GENERATING and the next state is GENERATING.
REQ-033 Image map SHALL be IDLE=0, PAUSED=1, GAME_OVER=2, GENERATING=3, LIFE_LOST=4, RUNNING=5.
REQ-034 All outputs other than o_regenerate_level and o_image_number SHALL be registered.

Reset
REQ-035 When rst_n is low, all of the following SHALL hold: FSM=IDLE, rating=0, high score=0, level=0, lives=NUM_LIVES, respawn counter=0, o_new_record=0.
REQ-036 Reset asserted mid-game SHALL abort immediately and clear the high score.
REQ-037 After reset, o_regenerate_level and o_game_running SHALL be 0 and o_image_number SHALL be 0.

Configuration
REQ-038 Macro GAME_SESSION_HIGH_SCORE_EN defined: on entry to GAME_OVER, if rating > high score, high score SHALL load rating and o_new_record SHALL pulse for one cycle.
REQ-039 Macro GAME_SESSION_HIGH_SCORE_EN undefined: the high-score register SHALL be omitted, and o_high_score and o_new_record SHALL be tied to 0.

Structure
REQ-040 The state enum (3-bit, explicit encodings) and the image-number constants SHALL be placed in package game_pkg.
REQ-041 The respawn down-counter SHALL be a sub-module, game_delay_timer (load, count, done).

Verification
REQ-042 Scenario: NUM_LIVES=3; start, ready, then 3 wins -> rating=3, level=3, and 4 regenerate pulses in total.
REQ-043 Scenario: RUNNING, lives=3, lose -> lives=2; LIFE_LOST for exactly 16 cycles; then one regenerate pulse; rating unchanged.
REQ-044 Scenario: in RUNNING, win and lose in the same cycle -> GENERATING and rating+1, lives unchanged.
REQ-045 Scenario: rating=5, high score=2, last life lost -> GAME_OVER, image=2, high score=5, one o_new_record pulse; a second game ending at 4 gives no pulse.
REQ-046 Scenario: pause in RUNNING, then lose while PAUSED -> ignored, lives unchanged; start -> RUNNING, o_game_running=1.
REQ-047 Scenario: RATING_WIDTH=2 with 5 wins -> rating saturates at 3; rst_n pulsed mid-RUNNING -> IDLE with all counters at their reset values.

Source files
------------

// File: rtl/game_pkg.sv
// Shared types for the game session controller: FSM state encoding and
// overlay image-number constants.
package game_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_GENERATING = 3'd1,
    ST_RUNNING    = 3'd2,
    ST_PAUSED     = 3'd3,
    ST_LIFE_LOST  = 3'd4,
    ST_GAME_OVER  = 3'd5
  } state_t;

  localparam int unsigned IMG_CONST_W = 3;

  localparam logic [IMG_CONST_W-1:0] IMG_IDLE       = 3'd0;
  localparam logic [IMG_CONST_W-1:0] IMG_PAUSED     = 3'd1;
  localparam logic [IMG_CONST_W-1:0] IMG_GAME_OVER  = 3'd2;
  localparam logic [IMG_CONST_W-1:0] IMG_GENERATING = 3'd3;
  localparam logic [IMG_CONST_W-1:0] IMG_LIFE_LOST  = 3'd4;
  localparam logic [IMG_CONST_W-1:0] IMG_RUNNING    = 3'd5;

  // Overlay image shown for each session state.
  function automatic logic [IMG_CONST_W-1:0] image_of(input state_t s);
    logic [IMG_CONST_W-1:0] img;
    img = IMG_IDLE;
    case (s)
      ST_IDLE:       img = IMG_IDLE;
      ST_PAUSED:     img = IMG_PAUSED;
      ST_GAME_OVER:  img = IMG_GAME_OVER;
      ST_GENERATING: img = IMG_GENERATING;
      ST_LIFE_LOST:  img = IMG_LIFE_LOST;
      ST_RUNNING:    img = IMG_RUNNING;
      default:       img = IMG_IDLE;
    endcase
    return img;
  endfunction

endpackage

// File: rtl/game_delay_timer.sv
// Loadable down-counter used to time the respawn pause after a lost life.
// done is high whenever the count has reached zero.
module game_delay_timer #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             count,
  output logic             done
);

  logic [WIDTH-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_value;
    end else if (count && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/game_session_ctrl.sv
// Game session sequencer: level generation handshake, lives, rating, level and
// overlay image select. High-score tracking is built only with GAME_SESSION_HIGH_SCORE_EN.
module game_session_ctrl
  import game_pkg::*;
#(
  parameter int unsigned RATING_WIDTH   = 8,
  parameter int unsigned LEVEL_WIDTH    = 4,
  parameter int unsigned NUM_LIVES      = 3,
  parameter int unsigned RESPAWN_CYCLES = 16,
  parameter int unsigned NUM_IMAGES     = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          i_is_win,
  input  logic                          i_is_lose,
  input  logic                          i_ready,
  input  logic                          i_start_game,
  input  logic                          i_pause_game,
  output logic                          o_regenerate_level,
  output logic                          o_game_running,
  output logic [RATING_WIDTH-1:0]       o_current_rating,
  output logic [RATING_WIDTH-1:0]       o_high_score,
  output logic                          o_new_record,
  output logic [2:0]                    o_lives,
  output logic [LEVEL_WIDTH-1:0]        o_level,
  output logic [$clog2(NUM_IMAGES)-1:0] o_image_number
);

  localparam int unsigned IMG_W  = $clog2(NUM_IMAGES);
  localparam int unsigned CNT_W  = (RESPAWN_CYCLES > 1) ? $clog2(RESPAWN_CYCLES) : 1;
  localparam int unsigned LIVES_W = 3;

  state_t state_q, state_d;

  logic                    new_game;
  logic                    do_win;
  logic                    do_lose;
  logic                    timer_load;
  logic                    timer_count;
  logic                    timer_done;
  logic [RATING_WIDTH-1:0] rating_q;
  logic [LEVEL_WIDTH-1:0]  level_q;
  logic [LIVES_W-1:0]      lives_q;
  logic                    running_q;

  game_delay_timer #(
    .WIDTH (CNT_W)
  ) u_respawn_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (timer_load),
    .load_value (CNT_W'(RESPAWN_CYCLES - 1)),
    .count      (timer_count),
    .done       (timer_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state plus the one-cycle action strobes that update the counters.
  always_comb begin
    state_d     = state_q;
    new_game    = 1'b0;
    do_win      = 1'b0;
    do_lose     = 1'b0;
    timer_load  = 1'b0;
    timer_count = 1'b0;
    case (state_q)
      ST_IDLE, ST_GAME_OVER: begin
        if (i_start_game) begin
          state_d  = ST_GENERATING;
          new_game = 1'b1;
        end
      end
      ST_GENERATING: begin
        if (i_ready) begin
          state_d = ST_RUNNING;
        end
      end
      ST_RUNNING: begin
        if (i_is_win) begin
          state_d = ST_GENERATING;
          do_win  = 1'b1;
        end else if (i_is_lose) begin
          do_lose = 1'b1;
          if (lives_q > LIVES_W'(1)) begin
            state_d    = ST_LIFE_LOST;
            timer_load = 1'b1;
          end else begin
            state_d = ST_GAME_OVER;
          end
        end else if (i_pause_game) begin
          state_d = ST_PAUSED;
        end
      end
      ST_PAUSED: begin
        if (i_start_game) begin
          state_d = ST_RUNNING;
        end
      end
      ST_LIFE_LOST: begin
        if (timer_done) begin
          state_d = ST_GENERATING;
        end else begin
          timer_count = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Session counters; rating and level saturate instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rating_q  <= '0;
      level_q   <= '0;
      lives_q   <= LIVES_W'(NUM_LIVES);
      running_q <= 1'b0;
    end else begin
      running_q <= (state_d == ST_RUNNING);
      if (new_game) begin
        rating_q <= '0;
        level_q  <= '0;
        lives_q  <= LIVES_W'(NUM_LIVES);
      end else if (do_win) begin
        if (rating_q != '1) rating_q <= rating_q + 1'b1;
        if (level_q != '1)  level_q  <= level_q + 1'b1;
      end else if (do_lose) begin
        lives_q <= lives_q - 1'b1;
      end
    end
  end

`ifdef GAME_SESSION_HIGH_SCORE_EN
  logic [RATING_WIDTH-1:0] high_score_q;
  logic                    new_record_q;
  logic                    game_over_entry;

  assign game_over_entry = (state_q == ST_RUNNING) && (state_d == ST_GAME_OVER);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      high_score_q <= '0;
      new_record_q <= 1'b0;
    end else begin
      new_record_q <= 1'b0;
      if (game_over_entry && (rating_q > high_score_q)) begin
        high_score_q <= rating_q;
        new_record_q <= 1'b1;
      end
    end
  end

  assign o_high_score = high_score_q;
  assign o_new_record = new_record_q;
`else
  assign o_high_score = '0;
  assign o_new_record = 1'b0;
`endif

  assign o_regenerate_level = (state_q != ST_GENERATING) && (state_d == ST_GENERATING);
  assign o_image_number     = IMG_W'(image_of(state_q));
  assign o_game_running     = running_q;
  assign o_current_rating   = rating_q;
  assign o_lives            = lives_q;
  assign o_level            = level_q;

endmodule

// File: tb/tb_game_session_ctrl.sv
// Directed vector bench for game_session_ctrl: a default instance plus a
// 2-bit-rating instance driven by the same stimulus.
module tb_game_session_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  logic i_is_win, i_is_lose, i_ready, i_start_game, i_pause_game;

  logic       regen, running, new_rec;
  logic [7:0] rating, high;
  logic [2:0] lives;
  logic [3:0] level;
  logic [2:0] image;

  logic       regen_s, running_s, new_rec_s;
  logic [1:0] rating_s, high_s;
  logic [2:0] lives_s;
  logic [3:0] level_s;
  logic [2:0] image_s;

  int n_chk  = 0;
  int n_fail = 0;
  logic last_regen;

  always #5 clk = ~clk;

  game_session_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .i_is_win(i_is_win), .i_is_lose(i_is_lose), .i_ready(i_ready),
    .i_start_game(i_start_game), .i_pause_game(i_pause_game),
    .o_regenerate_level(regen), .o_game_running(running),
    .o_current_rating(rating), .o_high_score(high), .o_new_record(new_rec),
    .o_lives(lives), .o_level(level), .o_image_number(image)
  );

  game_session_ctrl #(.RATING_WIDTH(2)) dut_s (
    .clk(clk), .rst_n(rst_n),
    .i_is_win(i_is_win), .i_is_lose(i_is_lose), .i_ready(i_ready),
    .i_start_game(i_start_game), .i_pause_game(i_pause_game),
    .o_regenerate_level(regen_s), .o_game_running(running_s),
    .o_current_rating(rating_s), .o_high_score(high_s), .o_new_record(new_rec_s),
    .o_lives(lives_s), .o_level(level_s), .o_image_number(image_s)
  );

  typedef struct {
    logic start, pause, win, lose, ready;
    int   regen, running, img, rating, level, lives;
  } vec_t;

  vec_t vecs[16];

  function automatic vec_t mk(logic s, logic p, logic w, logic l, logic r,
                              int rg, int rn, int im, int ra, int lv, int li);
    vec_t v;
    v.start = s; v.pause = p; v.win = w; v.lose = l; v.ready = r;
    v.regen = rg; v.running = rn; v.img = im; v.rating = ra; v.level = lv; v.lives = li;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    i_start_game = 1'b0; i_pause_game = 1'b0;
    i_is_win = 1'b0; i_is_lose = 1'b0; i_ready = 1'b0;
  endtask

  // One clock of stimulus; regen is sampled before the edge, state after it.
  task automatic step(input logic s, input logic p, input logic w, input logic l, input logic r);
    @(negedge clk);
    i_start_game = s; i_pause_game = p; i_is_win = w; i_is_lose = l; i_ready = r;
    #1;
    last_regen = regen;
    @(posedge clk);
    #1;
    clear_inputs();
  endtask

  // Counts LIFE_LOST cycles and regenerate pulses while driving ignored inputs.
  task automatic wait_respawn(output int n_ll, output int n_rg);
    n_ll = 0;
    n_rg = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #1;
      if (int'(image) == 3) break;
      if (int'(image) == 4) n_ll++;
      if (regen) n_rg++;
      i_is_win = 1'b1; i_is_lose = 1'b1; i_pause_game = 1'b1;
    end
    clear_inputs();
  endtask

  task automatic win_cycle();
    step(0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 1);
  endtask

  task automatic lose_respawn(input string tag);
    int n_ll, n_rg;
    step(0, 0, 0, 1, 0);
    wait_respawn(n_ll, n_rg);
    chk({tag, ".ll_cycles"}, n_ll, 16);
    chk({tag, ".ll_regen"}, n_rg, 1);
    step(0, 0, 0, 0, 1);
  endtask

  int exp_hs, exp_nr, n_ll, n_rg;

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    last_regen = 1'b0;
`ifdef GAME_SESSION_HIGH_SCORE_EN
    exp_hs = 5;
    exp_nr = 1;
`else
    exp_hs = 0;
    exp_nr = 0;
`endif

    //            s  p  w  l  r  rg rn im ra lv li
    vecs[0]  = mk(1, 0, 0, 0, 0, 1, 0, 3, 0, 0, 3);
    vecs[1]  = mk(1, 0, 1, 1, 0, 0, 0, 3, 0, 0, 3);
    vecs[2]  = mk(0, 0, 0, 0, 1, 0, 1, 5, 0, 0, 3);
    vecs[3]  = mk(0, 0, 1, 0, 0, 1, 0, 3, 1, 1, 3);
    vecs[4]  = mk(0, 0, 0, 0, 1, 0, 1, 5, 1, 1, 3);
    vecs[5]  = mk(0, 0, 1, 1, 0, 1, 0, 3, 2, 2, 3);
    vecs[6]  = mk(0, 0, 0, 0, 1, 0, 1, 5, 2, 2, 3);
    vecs[7]  = mk(0, 1, 1, 0, 0, 1, 0, 3, 3, 3, 3);
    vecs[8]  = mk(0, 0, 0, 0, 1, 0, 1, 5, 3, 3, 3);
    vecs[9]  = mk(0, 1, 0, 0, 0, 0, 0, 1, 3, 3, 3);
    vecs[10] = mk(0, 0, 0, 1, 0, 0, 0, 1, 3, 3, 3);
    vecs[11] = mk(0, 0, 1, 0, 0, 0, 0, 1, 3, 3, 3);
    vecs[12] = mk(0, 0, 0, 0, 1, 0, 0, 1, 3, 3, 3);
    vecs[13] = mk(1, 0, 0, 0, 0, 0, 1, 5, 3, 3, 3);
    vecs[14] = mk(1, 0, 0, 0, 0, 0, 1, 5, 3, 3, 3);
    vecs[15] = mk(0, 0, 0, 1, 0, 0, 0, 4, 3, 3, 2);

    repeat (2) @(posedge clk);
    #1;
    chk("rst.running", int'(running), 0);
    chk("rst.regen", int'(regen), 0);
    chk("rst.image", int'(image), 0);
    chk("rst.rating", int'(rating), 0);
    chk("rst.level", int'(level), 0);
    chk("rst.lives", int'(lives), 3);
    chk("rst.high", int'(high), 0);
    chk("rst.new_record", int'(new_rec), 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      step(vecs[i].start, vecs[i].pause, vecs[i].win, vecs[i].lose, vecs[i].ready);
      chk($sformatf("vec%0d.regen", i), int'(last_regen), vecs[i].regen);
      chk($sformatf("vec%0d.running", i), int'(running), vecs[i].running);
      chk($sformatf("vec%0d.image", i), int'(image), vecs[i].img);
      chk($sformatf("vec%0d.rating", i), int'(rating), vecs[i].rating);
      chk($sformatf("vec%0d.level", i), int'(level), vecs[i].level);
      chk($sformatf("vec%0d.lives", i), int'(lives), vecs[i].lives);
    end
    chk("small.rating_at3", int'(rating_s), 3);

    // Respawn window entered by vec15.
    wait_respawn(n_ll, n_rg);
    chk("respawn1.ll_cycles", n_ll, 16);
    chk("respawn1.regen", n_rg, 1);
    chk("respawn1.rating", int'(rating), 3);
    chk("respawn1.lives", int'(lives), 2);
    step(0, 0, 0, 0, 1);
    chk("respawn1.running", int'(running), 1);

    // Two more wins: rating 5, small instance saturated at 3.
    win_cycle();
    win_cycle();
    chk("g1.rating", int'(rating), 5);
    chk("g1.level", int'(level), 5);
    chk("small.rating_sat", int'(rating_s), 3);
    chk("small.level", int'(level_s), 5);

    lose_respawn("g1.l2");
    chk("g1.lives1", int'(lives), 1);
    step(0, 0, 0, 1, 0);
    chk("g1.over_image", int'(image), 2);
    chk("g1.over_lives", int'(lives), 0);
    chk("g1.over_running", int'(running), 0);
    chk("g1.over_rating", int'(rating), 5);
    chk("g1.high", int'(high), exp_hs);
    chk("g1.new_record", int'(new_rec), exp_nr);
    step(0, 0, 0, 0, 0);
    chk("g1.new_record_drop", int'(new_rec), 0);
    chk("g1.still_over", int'(image), 2);

    // Second game ends at rating 4: no new record.
    step(1, 0, 0, 0, 0);
    chk("g2.start_regen", int'(last_regen), 1);
    chk("g2.rating_clr", int'(rating), 0);
    chk("g2.lives_load", int'(lives), 3);
    step(0, 0, 0, 0, 1);
    for (int k = 0; k < 4; k++) win_cycle();
    lose_respawn("g2.l1");
    lose_respawn("g2.l2");
    step(0, 0, 0, 1, 0);
    chk("g2.over_image", int'(image), 2);
    chk("g2.rating", int'(rating), 4);
    chk("g2.new_record", int'(new_rec), 0);
    step(0, 0, 0, 0, 0);
    chk("g2.new_record_late", int'(new_rec), 0);
    chk("g2.high", int'(high), exp_hs);

    // Asynchronous reset in the middle of RUNNING.
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    win_cycle();
    chk("g3.running", int'(running), 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst.image", int'(image), 0);
    chk("arst.running", int'(running), 0);
    chk("arst.regen", int'(regen), 0);
    chk("arst.rating", int'(rating), 0);
    chk("arst.level", int'(level), 0);
    chk("arst.lives", int'(lives), 3);
    chk("arst.high", int'(high), 0);
    chk("arst.small_rating", int'(rating_s), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst.image", int'(image), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
